// File: rtl/mul_iter_if.sv
// Request/response bundle for the iterative multiplier.
// Ports: master drives in_valid/in_op/in_a/in_b/in_tag/out_ready and receives in_ready/out_valid/out_result/out_tag.
// Modports: master (requester/consumer side), slave (multiplier side).
interface mul_iter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (MUL/MULH/MULHU/MULHSU) on sign-magnitude operands, one multiplier bit per cycle.
// Latency: WIDTH cycles accept->out_valid; with MUL_ITER_EARLY_OUT_EN defined, max(1, MSB index of |b| + 1) cycles.
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready low until the block is idle again.
// Ports: clk, rst (async active-high), flush (sync abort), bus (mul_iter_if.slave request/response bundle).
// Optional macro: MUL_ITER_EARLY_OUT_EN -- finish as soon as the remaining multiplier is zero.
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mul_iter_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b11;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("mul_iter: WIDTH must be even and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [1:0]         op;
    logic [TAG_W-1:0]   tag;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               last;
    logic               in_ready_c;
    logic               out_valid_c;

    // Operand conditioning at accept time. Magnitudes are kept as unsigned
    // WIDTH-bit values, so negating the most-negative input yields exactly
    // 2^(WIDTH-1) and never overflows.
    logic               a_signed;
    logic               b_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign a_signed = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU);
    assign b_signed = (bus.in_op == OP_MULH);
    assign a_neg    = a_signed & bus.in_a[WIDTH-1];
    assign b_neg    = b_signed & bus.in_b[WIDTH-1];
    assign a_mag    = a_neg ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
    assign b_mag    = b_neg ? (~bus.in_b + WIDTH'(1)) : bus.in_b;

    assign accept   = bus.in_valid & in_ready_c;

    // Edge that processes the final multiplier bit.
    always_comb begin
        last = 1'b0;
`ifdef MUL_ITER_EARLY_OUT_EN
        last = (cnt == LAST_CNT) || (mplier[WIDTH-1:1] == '0);
`else
        last = (cnt == LAST_CNT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush overrides every other transition, including acceptance in IDLE
    // (in_ready_c already masks it) and the DONE handshake.
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = ~flush;
                if (bus.in_valid && !flush) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= '0;
            tag    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op     <= bus.in_op;
            tag    <= bus.in_tag;
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= '0;
        end else if ((state == BUSY) && !flush) begin
            if (mplier[0]) begin
                acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
            end
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Sign is re-applied on the way out; acc/neg/op are frozen in DONE so the
    // selected half stays stable until the handshake.
    logic [2*WIDTH-1:0] product;

    assign product        = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    assign bus.out_result = (op == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
    assign bus.out_tag    = tag;
    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter (WIDTH=32, TAG_W=4).
// Expected results are queued when a request is driven and popped when the result appears.
// Honours MUL_ITER_EARLY_OUT_EN for the expected latency.
module tb_mul_iter;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic clk;
    logic rst;
    logic flush;

    mul_iter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    mul_iter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference product from full-width multiplication of extended operands.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [63:0] sa, ua, sbx, ub, p;
        sa  = {{32{a[31]}}, a};
        ua  = {32'b0, a};
        sbx = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        case (op)
            2'b00:   begin p = ua * ub;  return p[31:0];  end
            2'b01:   begin p = sa * sbx; return p[63:32]; end
            2'b10:   begin p = ua * ub;  return p[63:32]; end
            default: begin p = sa * ub;  return p[63:32]; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] m;
        int n;
        int early;
`ifdef MUL_ITER_EARLY_OUT_EN
        early = 1;
`else
        early = 0;
`endif
        m = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
        n = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) n = i + 1;
        end
        return (early != 0) ? n : WIDTH;
    endfunction

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_in_ready", bus.in_ready, 1);
    endtask

    // Issue one request at a negedge; hold = cycles to stall out_ready in DONE.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [TAG_W-1:0] tg, input logic [WIDTH-1:0] exp_res, input int hold);
        exp_t e;
        int cyc;
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] t;
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tg;
        bus.out_ready = (hold == 0);
        e.tag = tg;
        e.res = exp_res;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, exp_lat(op, b));
        e = sb_q.pop_front();
        check("result", bus.out_result, e.res);
        check("tag", bus.out_tag, e.tag);
        if (hold > 0) begin
            r = bus.out_result;
            t = bus.out_tag;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", bus.out_valid, 1);
                check("hold_result", bus.out_result, r);
                check("hold_tag", bus.out_tag, t);
                check("hold_in_ready", bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;
        logic [1:0] rop;
        logic [WIDTH-1:0] ra, rb;

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 2'b00;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        run_op(2'b00, 32'd7, 32'd6, 4'd3, 32'h0000002A, 0);
        run_op(2'b01, 32'h80000000, 32'h80000000, 4'd1, 32'h40000000, 0);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'hFFFFFFFE, 0);
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 4'd4, 32'hFFFFFFFF, 0);
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000002, 4'd5, 32'hFFFFFFFF, 0);
        run_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 4'd6, 32'h00000001, 0);
        run_op(2'b01, 32'h80000000, 32'h7FFFFFFF, 4'd7, 32'hC0000000, 0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 4'd8, 32'h80000000, 0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 4'd9, 32'h00000000, 0);
        run_op(2'b00, 32'd5, 32'd3, 4'd10, 32'd15, 0);
        run_op(2'b00, 32'h00001234, 32'd0, 4'd11, 32'd0, 0);
        run_op(2'b01, 32'd0, 32'hFFFFFFFF, 4'd12, 32'd0, 0);
        run_op(2'b10, 32'd1, 32'h80000000, 4'd13, 32'd0, 0);

        // Backpressure: result held for 5 cycles.
        run_op(2'b00, 32'd100, 32'd200, 4'd14, 32'd20000, 5);

        // Random operands against the reference model.
        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 3) rb = rb & 32'h000000FF;
            run_op(rop, ra, rb, 4'($urandom_range(0, 15)), model(rop, ra, rb), 0);
        end

        // flush on the 10th BUSY cycle: back to IDLE, no result.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_op = 2'b00;
        bus.in_a = 32'd9;
        bus.in_b = 32'hFFFFFFFF;
        bus.in_tag = 4'd2;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 1);
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // A request presented together with flush is not accepted.
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_b = 32'd1;
        #1;
        check("flush_blocks_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) seen++;
        end
        check("flush_req_dropped", seen, 0);
        bus.out_ready = 1'b0;
        run_op(2'b00, 32'd3, 32'd4, 4'd15, 32'h0000000C, 0);

        // flush wins over the DONE handshake.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_op = 2'b00;
        bus.in_a = 32'd2;
        bus.in_b = 32'd2;
        bus.in_tag = 4'd1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", bus.out_valid, 1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("flush_done_valid", bus.out_valid, 0);
        check("flush_done_ready", bus.in_ready, 1);

        // Asynchronous reset mid-operation.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_op = 2'b10;
        bus.in_a = 32'hFFFFFFFF;
        bus.in_b = 32'hFFFFFFFF;
        bus.in_tag = 4'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_result", bus.out_result, 0);
        check("arst_out_tag", bus.out_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("arst_no_result", seen, 0);
        bus.out_ready = 1'b0;
        run_op(2'b11, 32'hFFFFFFFE, 32'd3, 4'd6, model(2'b11, 32'hFFFFFFFE, 32'd3), 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
